// File: rtl/char_plane_write_ctrl.sv
// char_plane_write_ctrl: write-port controller for a ROWS x COLS character plane.
// It shares the single write port between a direct-address requester (A) and a console
// stream requester (B) with an auto-advancing cursor, and it sequences a full-screen clear.
// Latency: accepted request -> wr_* presented the following cycle. Clear: one cell per cycle.
// Backpressure: a_ready/b_ready are combinational grants. Both are 0 while clearing or
//   while a clear is starting. Round-robin is used when both requesters are valid.
//
// Build option: define CHAR_PLANE_CLEAR_EN to compile in the CLEAR state, busy and
//   clear_req handling. When it is undefined, clear_req is ignored and busy is tied 0.
//
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   clear_req / busy          : full-screen clear pulse / clear in progress
//   a_valid/a_row/a_col/a_char, a_ready : direct write request
//   b_valid/b_char, b_ready   : console byte (0x0A newline, 0x08 backspace)
//   cur_row/cur_col           : console cursor
//   wr_en/wr_row/wr_col/wr_char : registered plane write port
//   drop_err                  : sticky, set when an A request has a column out of range
module char_plane_write_ctrl #(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         COLS      = 40,
  parameter int         ROWS      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_req,
  output logic       busy,
  input  logic       a_valid,
  input  logic [3:0] a_row,
  input  logic [5:0] a_col,
  input  logic [7:0] a_char,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_char,
  output logic       b_ready,
  output logic [3:0] cur_row,
  output logic [5:0] cur_col,
  output logic       wr_en,
  output logic [3:0] wr_row,
  output logic [5:0] wr_col,
  output logic [7:0] wr_char,
  output logic       drop_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [5:0] COLS_W   = 6'(COLS);
  localparam logic [5:0] COL_LAST = 6'(COLS - 1);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic       GRANT_A  = 1'b0;
  localparam logic       GRANT_B  = 1'b1;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;

  state_e     state_q, state_d;
  logic [3:0] cur_row_q, cur_row_d;
  logic [5:0] cur_col_q, cur_col_d;
  logic       last_grant_q, last_grant_d;
  logic       drop_err_q, drop_err_d;
  logic       wr_en_q, wr_en_d;
  logic [3:0] wr_row_q, wr_row_d;
  logic [5:0] wr_col_q, wr_col_d;
  logic [7:0] wr_char_q, wr_char_d;

  logic       clear_start;
  logic       grant_a;
  logic       grant_b;

`ifdef CHAR_PLANE_CLEAR_EN
  assign clear_start = (state_q == IDLE) && clear_req;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign clear_start      = 1'b0;
`endif

  function automatic logic [3:0] row_inc(input logic [3:0] r);
    return (r == ROW_LAST) ? 4'd0 : r + 4'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    last_grant_d = last_grant_q;
    drop_err_d   = drop_err_q;
    wr_en_d      = 1'b0;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_char_d    = wr_char_q;
    grant_a      = 1'b0;
    grant_b      = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          // Cell (0,0) is presented on the first busy cycle. This lines the
          // sweep up with busy, so busy covers all ROWS*COLS presented writes.
          state_d   = CLEAR;
          wr_en_d   = 1'b1;
          wr_row_d  = 4'd0;
          wr_col_d  = 6'd0;
          wr_char_d = FILL_CHAR;
        end else begin
          grant_a = a_valid && (!b_valid || (last_grant_q == GRANT_B));
          grant_b = b_valid && !grant_a;

          if (grant_a) begin
            last_grant_d = GRANT_A;
            if (a_col < COLS_W) begin
              wr_en_d   = 1'b1;
              wr_row_d  = a_row;
              wr_col_d  = a_col;
              wr_char_d = a_char;
            end else begin
              drop_err_d = 1'b1;
            end
          end else if (grant_b) begin
            last_grant_d = GRANT_B;
            if (b_char == CH_NL) begin
              cur_col_d = 6'd0;
              cur_row_d = row_inc(cur_row_q);
            end else if (b_char == CH_BS) begin
              if (cur_col_q != 6'd0) begin
                cur_col_d = cur_col_q - 6'd1;
                wr_en_d   = 1'b1;
                wr_row_d  = cur_row_q;
                wr_col_d  = cur_col_q - 6'd1;
                wr_char_d = FILL_CHAR;
              end
            end else begin
              wr_en_d   = 1'b1;
              wr_row_d  = cur_row_q;
              wr_col_d  = cur_col_q;
              wr_char_d = b_char;
              if (cur_col_q == COL_LAST) begin
                cur_col_d = 6'd0;
                cur_row_d = row_inc(cur_row_q);
              end else begin
                cur_col_d = cur_col_q + 6'd1;
              end
            end
          end
        end
      end

      CLEAR: begin
        // While clearing, the write registers always hold the most recently
        // presented sweep cell. They therefore double as the sweep pointer.
        if ((wr_row_q == ROW_LAST) && (wr_col_q == COL_LAST)) begin
          state_d   = IDLE;
          cur_row_d = 4'd0;
          cur_col_d = 6'd0;
        end else begin
          wr_en_d   = 1'b1;
          wr_char_d = FILL_CHAR;
          if (wr_col_q == COL_LAST) begin
            wr_col_d = 6'd0;
            wr_row_d = wr_row_q + 4'd1;
          end else begin
            wr_col_d = wr_col_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_row_q    <= 4'd0;
      cur_col_q    <= 6'd0;
      last_grant_q <= GRANT_B;
      drop_err_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_row_q     <= 4'd0;
      wr_col_q     <= 6'd0;
      wr_char_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      last_grant_q <= last_grant_d;
      drop_err_q   <= drop_err_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_char_q    <= wr_char_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;
  assign wr_en    = wr_en_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign wr_char  = wr_char_q;
  assign drop_err = drop_err_q;

endmodule

// File: doc/char_plane_write_ctrl.md
# char_plane_write_ctrl

Write-port controller for the 16-row by 40-column character plane (8-bit character IDs, 4-bit row, 6-bit column). It shares the plane's single write port between a direct-address requester (game/UI logic) and a console stream requester that has an auto-advancing cursor. It also sequences a full-screen clear. It drives the plane's write row, column, ID and enable inputs, and sits between the game logic, the UART/keyboard console path and the plane.

## Interface
Parameters:
- FILL_CHAR, 8'h20: character ID written by clear and backspace.
- COLS, 40: visible columns; column index must be < COLS.
- ROWS, 16: visible rows.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- clear_req  in  1  single-cycle pulse; starts a full-screen clear.
- busy  out  1  high while clearing.
- a_valid  in  1  direct write request.
- a_row  in  4  target row.
- a_col  in  6  target column.
- a_char  in  8  character ID.
- a_ready  out  1  request A accepted this cycle (combinational).
- b_valid  in  1  console byte request.
- b_char  in  8  console byte.
- b_ready  out  1  request B accepted this cycle (combinational).
- cur_row  out  4  console cursor row.
- cur_col  out  6  console cursor column.
- wr_en  out  1  plane write enable (registered).
- wr_row  out  4  plane write row (registered).
- wr_col  out  6  plane write column (registered).
- wr_char  out  8  plane write ID (registered).
- drop_err  out  1  sticky; set when an A request has a_col ≥ COLS.

## Operation
- FSM states: IDLE, CLEAR.
- IDLE → CLEAR on clear_req. CLEAR → IDLE after the write to cell (ROWS-1, COLS-1).
- clear_req seen in CLEAR is ignored.
- CLEAR sweeps the cells row-major, (0,0) through (15,39), writing FILL_CHAR at one cell per cycle: 640 writes total.
- In CLEAR, a_ready = b_ready = 0. Clear has absolute priority.
- Leaving CLEAR sets the cursor to (0,0).
- In IDLE, arbitration is round-robin between A and B using a last_grant bit.
  - Only one valid: that requester gets ready.
  - Both valid: the requester not granted last time wins.
  - last_grant resets to B, so A wins the first contention.
- A accepted with a_col < COLS: write (a_row, a_col, a_char).
- A accepted with a_col ≥ COLS: no write, drop_err set. The request is still consumed (a_ready=1).
- B accepted, b_char = 8'h0A (newline): no write; cur_col←0; cur_row←cur_row+1, wrapping 15→0.
- B accepted, b_char = 8'h08 (backspace):
  - cur_col>0: cur_col−1, and FILL_CHAR is written at (cur_row, cur_col−1).
  - cur_col=0: no-op.
- B accepted, any other byte: write b_char at the cursor, then advance the cursor.
  - cur_col=COLS−1 → cur_col←0, cur_row+1 with wrap 15→0.
- No scrolling. The row wrap overwrites row 0.
- A writes never move the cursor.

## Timing
- Reset values:
  - State IDLE; busy=0.
  - wr_en=0; wr_row, wr_col, wr_char = 0.
  - cur_row=0, cur_col=0.
  - drop_err=0; last_grant=B.
- Write latency: wr_* are valid and wr_en=1 on the cycle after the handshake (valid&&ready at edge N → write presented during cycle N+1).
- Throughput: one write per cycle.
- busy rises the cycle after clear_req and falls the cycle after the last clear write is presented. Busy is high for exactly 640 cycles.
- clear_req in the same cycle as a_valid/b_valid in IDLE: clear wins; readys stay 0 that cycle and the requests are held by their sources.
- Reset mid-clear: the FSM returns to IDLE immediately and the sweep is abandoned. The partially cleared screen is left as is.
- A cursor update is visible on cur_row/cur_col the cycle after acceptance.

## Configuration
- CHAR_PLANE_CLEAR_EN:
  - Defined: the CLEAR state, busy and clear_req handling are compiled in as above.
  - Undefined: clear_req is ignored, busy is tied 0, and the FSM is IDLE-only. All other behaviour is identical.

## Test plan
- Reset, then clear_req pulse → busy high for 640 cycles; writes are (0,0)…(15,39) all 8'h20; cursor (0,0) after.
- B streams "AB" at cursor (0,38) → writes (0,38)=0x41 and (0,39)=0x42; cursor becomes (1,0).
- B sends 0x0A at row 15 → no wr_en; cursor becomes (0,0). B sends 0x08 at col 0 → no-op.
- A and B both valid for 4 cycles after reset → grants A,B,A,B; four consecutive wr_en cycles.
- A with a_col=40 → a_ready=1, no write, drop_err=1 and it stays 1.
- rst_n low mid-clear (cycle 100) → busy=0 and wr_en=0 on the next edge; the next clear restarts at (0,0).
